alarm_trigger: RTL
==================

# alarm_trigger

Alarm sequencing stage directly downstream of the alarm-set register. Compares the stored 14-bit BCD alarm time against the running time-of-day and raises the ring condition. Manages snooze and ring timeout, and holds the puzzle request until the puzzle block reports a solve. Feeds the buzzer driver and the puzzle/display logic.

## Interface
- `SNOOZE_SEC`, default 300: seconds spent in snooze before re-ringing.
- `RING_TIMEOUT_SEC`, default 600: seconds of unanswered ringing before giving up.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; legal range 1–3.
- `clk`  in  1  100 MHz board clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arm_en`  in  1  level; alarm armed while high.
- `alarm_time`  in  14  stored alarm, BCD: [13:12] hour tens, [11:8] hour ones, [7:4] minute tens, [3:0] minute ones.
- `cur_time`  in  14  current time, same format.
- `sec_tick`  in  1  one-cycle pulse, once per second.
- `snooze`  in  1  one-cycle pulse, debounced upstream.
- `dismiss`  in  1  one-cycle pulse from the puzzle block on a solve.
- `ringing`  out  1  high in RINGING.
- `buzzer`  out  1  `ringing & beep_phase`.
- `puzzle_req`  out  1  high in RINGING or SNOOZE.
- `snooze_active`  out  1  high in SNOOZE.
- `snooze_cnt`  out  2  snoozes used in the current event.
- `alarm_invalid`  out  1  `alarm_time` is not a legal 00:00–23:59 BCD value.

## Operation
- State machine states: IDLE, ARMED, RINGING, SNOOZE, DONE.
- Match condition: `cur_time == alarm_time` and `!alarm_invalid`.
- IDLE → ARMED when `arm_en` is high.
- ARMED → RINGING on match.
- RINGING:
  - `dismiss` → DONE.
  - `snooze` with `snooze_cnt < MAX_SNOOZE` → SNOOZE; increments `snooze_cnt` and loads the snooze timer with SNOOZE_SEC.
  - `snooze` at the limit is ignored.
  - Ring timer reaching RING_TIMEOUT_SEC → DONE.
- SNOOZE:
  - `dismiss` → DONE.
  - Snooze timer decrements on each `sec_tick`.
  - The tick that takes the timer from 1 to 0 → RINGING; the ring timer clears on entry.
- DONE → ARMED once `cur_time != alarm_time`. This prevents retrigger within the same minute.
- `arm_en` low in any state → IDLE on the next edge. This clears both timers, `snooze_cnt` and `beep_phase`, and has top priority.
- Simultaneous `dismiss` and `snooze`: `dismiss` wins.
- Simultaneous `dismiss` and timer expiry: `dismiss` wins.
- `snooze_cnt` clears on entry to DONE or IDLE.
- `beep_phase` toggles on each `sec_tick` while in RINGING and clears on RINGING exit.
- `alarm_invalid` is combinational from `alarm_time`. It is invalid if any of:
  - hour tens > 2;
  - hour ones > 9;
  - hour ones > 3 when hour tens = 2;
  - minute tens > 5;
  - minute ones > 9.
- A change of `alarm_time` while in RINGING or SNOOZE does not cancel the event.

## Timing
- All outputs except `alarm_invalid` are registered.
- Reset values: state IDLE; `ringing`, `buzzer`, `puzzle_req`, `snooze_active` and `beep_phase` all 0; `snooze_cnt` 0; timers 0.
- Match seen at edge N → `ringing`/`puzzle_req` high after edge N+1.
- `snooze`/`dismiss` sampled at edge N → state and outputs update after edge N+1.
- Timer width: `$clog2(max+1)`.
- Timers saturate and never wrap.
- `sec_tick` coincident with state entry counts in the new state only when the entry state is SNOOZE; the loaded value is then decremented on the next tick, not that one.
- Reset asserted mid-ring silences `buzzer` asynchronously.

## Structure
- `alarm_pkg` contains:
  - state enum `alarm_state_t`;
  - BCD field slice constants;
  - function `bcd_time_valid()`, shared with the time-keeping block.
- Sub-module `sec_countdown`: loadable saturating down-counter driven by `sec_tick`, with a `zero` flag. Instanced for the snooze timer; the ring timer is an up-count in the top level.

## Test plan
Benches use SNOOZE_SEC=3, RING_TIMEOUT_SEC=5, MAX_SNOOZE=2.
- Arm, set `alarm_time`=14'h0730, step `cur_time` 0729→0730 → `ringing`=1 one cycle later; `buzzer` toggles each `sec_tick`.
- Ringing, pulse `snooze` → `snooze_active`=1, `snooze_cnt`=1; after 3 `sec_tick`s → `ringing`=1 again.
- Snooze twice, third `snooze` → ignored, `ringing` stays 1, `snooze_cnt`=2.
- Ringing, `dismiss` and `snooze` in the same cycle → DONE, `snooze_cnt`=0; no re-ring while `cur_time`=0730; re-arms at 0731.
- Ringing, no input for 5 ticks → DONE, `buzzer`=0.
- `alarm_time`=14'h2460 → `alarm_invalid`=1, never rings.
- Drop `arm_en`, or pulse `rst_n` low mid-ring → IDLE; all outputs 0.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: alarm state encoding, BCD time field slices and the time validity check
package alarm_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, RINGING, SNOOZE, DONE} alarm_state_t;
    localparam int HT_HI = 13, HT_LO = 12;
    localparam int HO_HI = 11, HO_LO = 8;
    localparam int MT_HI = 7, MT_LO = 4;
    localparam int MO_HI = 3, MO_LO = 0;
    function automatic logic bcd_time_valid(input logic [13:0] t);
        logic [1:0] ht;
        logic [3:0] ho, mt, mo;
        ht = t[HT_HI:HT_LO];
        ho = t[HO_HI:HO_LO];
        mt = t[MT_HI:MT_LO];
        mo = t[MO_HI:MO_LO];
        return !(ht > 2'd2 || ho > 4'd9 || (ht == 2'd2 && ho > 4'd3) || mt > 4'd5 || mo > 4'd9);
    endfunction
endpackage

// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if: control inputs and alarm status outputs of the alarm sequencer
interface alarm_trigger_if;
    logic        arm_en;
    logic [13:0] alarm_time;
    logic [13:0] cur_time;
    logic        sec_tick;
    logic        snooze;
    logic        dismiss;
    logic        ringing;
    logic        buzzer;
    logic        puzzle_req;
    logic        snooze_active;
    logic [1:0]  snooze_cnt;
    logic        alarm_invalid;
    modport master (
        output arm_en, alarm_time, cur_time, sec_tick, snooze, dismiss,
        input  ringing, buzzer, puzzle_req, snooze_active, snooze_cnt, alarm_invalid
    );
    modport slave (
        input  arm_en, alarm_time, cur_time, sec_tick, snooze, dismiss,
        output ringing, buzzer, puzzle_req, snooze_active, snooze_cnt, alarm_invalid
    );
endinterface

// File: rtl/sec_countdown.sv
// sec_countdown: loadable saturating down-counter stepped by a per-second tick
module sec_countdown #(
    parameter int MAX = 300
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       tick,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       zero
);
    localparam int W = $clog2(MAX + 1);
    assign zero = count == '0;
    // load beats a coincident tick so a fresh load always runs the full period
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= W'(MAX);
        else if (tick && !zero)
            count <= count - 1'b1;
endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: matches alarm time against time-of-day and sequences ring, snooze and timeout
import alarm_pkg::*;
module alarm_trigger #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 600,
    parameter int MAX_SNOOZE       = 3
) (
    input logic            clk,
    input logic            rst_n,
    alarm_trigger_if.slave bus
);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
    alarm_state_t  state;
    logic [RW-1:0] ring_t;
    logic [SW-1:0] sn_count;
    logic          sn_zero, sn_load, sn_expire, beep_phase, match, can_snooze;
    assign bus.alarm_invalid = !bcd_time_valid(bus.alarm_time);
    assign match      = bus.cur_time == bus.alarm_time && !bus.alarm_invalid;
    assign can_snooze = bus.snooze_cnt < 2'(MAX_SNOOZE);
    assign sn_load    = bus.arm_en && state == RINGING && !bus.dismiss && bus.snooze && can_snooze;
    assign sn_expire  = bus.sec_tick && (sn_zero || sn_count == SW'(1));
    sec_countdown #(.MAX(SNOOZE_SEC)) u_snooze (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!bus.arm_en),
        .load  (sn_load),
        .tick  (bus.sec_tick && state == SNOOZE),
        .count (sn_count),
        .zero  (sn_zero)
    );
    // outputs follow the registered state, so they lag a transition by one edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state             <= IDLE;
            ring_t            <= '0;
            beep_phase        <= 1'b0;
            bus.snooze_cnt    <= 2'd0;
            bus.ringing       <= 1'b0;
            bus.buzzer        <= 1'b0;
            bus.puzzle_req    <= 1'b0;
            bus.snooze_active <= 1'b0;
        end else begin
            bus.ringing       <= state == RINGING;
            bus.buzzer        <= state == RINGING && beep_phase;
            bus.puzzle_req    <= state == RINGING || state == SNOOZE;
            bus.snooze_active <= state == SNOOZE;
            if (!bus.arm_en) begin
                state          <= IDLE;
                ring_t         <= '0;
                beep_phase     <= 1'b0;
                bus.snooze_cnt <= 2'd0;
            end else
                case (state)
                    IDLE:    state <= ARMED;
                    ARMED:   if (match) begin
                        state      <= RINGING;
                        ring_t     <= '0;
                        beep_phase <= 1'b0;
                    end
                    RINGING: if (bus.dismiss || ring_t == RW'(RING_TIMEOUT_SEC)) begin
                        state          <= DONE;
                        beep_phase     <= 1'b0;
                        bus.snooze_cnt <= 2'd0;
                    end else if (bus.snooze && can_snooze) begin
                        state          <= SNOOZE;
                        beep_phase     <= 1'b0;
                        bus.snooze_cnt <= bus.snooze_cnt + 2'd1;
                    end else if (bus.sec_tick) begin
                        beep_phase <= !beep_phase;
                        ring_t     <= ring_t + RW'(1);
                    end
                    SNOOZE:  if (bus.dismiss) begin
                        state          <= DONE;
                        bus.snooze_cnt <= 2'd0;
                    end else if (sn_expire) begin
                        state      <= RINGING;
                        ring_t     <= '0;
                        beep_phase <= 1'b0;
                    end
                    DONE:    if (bus.cur_time != bus.alarm_time) state <= ARMED;
                    default: state <= IDLE;
                endcase
        end
endmodule
